// File: rtl/hazard_pipe_ctrl.sv
// rtl/hazard_pipe_ctrl.sv - register-tag pipeline tracker, load-use detect, stall/bubble generation
// Optional MULDIV_STALL_EN: freezes the tag pipeline while a multi-cycle divide occupies EX.
module hazard_pipe_ctrl #(
    parameter int REG_BITS = 5,
    parameter int DIV_LAT  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_regwrite,
    input  logic                id_memread,
    input  logic                id_div,
    input  logic                flush,
    output logic [REG_BITS-1:0] ex_rs1,
    output logic [REG_BITS-1:0] ex_rs2,
    output logic [REG_BITS-1:0] exmem_rd,
    output logic                exmem_regwrite,
    output logic [REG_BITS-1:0] memwb_rd,
    output logic                memwb_regwrite,
    output logic                stall,
    output logic                div_busy
);

    localparam logic [7:0] DIV_LOAD = 8'(DIV_LAT - 1);

    logic [REG_BITS-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_BITS-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_BITS-1:0] ex_rd_q, ex_rd_d;
    logic                ex_regwrite_q, ex_regwrite_d;
    logic                ex_memread_q, ex_memread_d;
    logic [REG_BITS-1:0] exmem_rd_q, exmem_rd_d;
    logic                exmem_regwrite_q, exmem_regwrite_d;
    logic [REG_BITS-1:0] memwb_rd_q, memwb_rd_d;
    logic                memwb_regwrite_q, memwb_regwrite_d;

    logic load_use;
    logic bubble;
    logic freeze;

    // ex_regwrite_q is already sanitised, so a load to x0 never triggers a stall
    assign load_use = id_valid && ex_memread_q && ex_regwrite_q &&
                      ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
    assign bubble   = flush || load_use || !id_valid;
    assign freeze   = div_busy;
    assign stall    = (load_use && !flush) || div_busy;

`ifdef MULDIV_STALL_EN
    logic [7:0] div_cnt_q, div_cnt_d;

    assign div_busy = (div_cnt_q != 8'd0);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (freeze) begin
            div_cnt_d = div_cnt_q - 8'd1;
        end else if (!bubble && id_div) begin
            div_cnt_d = DIV_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= 8'd0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end
`else
    logic unused_div;

    assign unused_div = ^{id_div, DIV_LOAD};
    assign div_busy   = 1'b0;
`endif

    always_comb begin
        ex_rs1_d         = ex_rs1_q;
        ex_rs2_d         = ex_rs2_q;
        ex_rd_d          = ex_rd_q;
        ex_regwrite_d    = ex_regwrite_q;
        ex_memread_d     = ex_memread_q;
        exmem_rd_d       = exmem_rd_q;
        exmem_regwrite_d = exmem_regwrite_q;
        memwb_rd_d       = memwb_rd_q;
        memwb_regwrite_d = memwb_regwrite_q;
        // A frozen pipeline also ignores flush: the branch that raised it is stuck in EX
        if (!freeze) begin
            exmem_rd_d       = ex_rd_q;
            exmem_regwrite_d = ex_regwrite_q;
            memwb_rd_d       = exmem_rd_q;
            memwb_regwrite_d = exmem_regwrite_q;
            if (bubble) begin
                ex_rs1_d      = '0;
                ex_rs2_d      = '0;
                ex_rd_d       = '0;
                ex_regwrite_d = 1'b0;
                ex_memread_d  = 1'b0;
            end else begin
                ex_rs1_d      = id_rs1;
                ex_rs2_d      = id_rs2;
                ex_rd_d       = id_rd;
                ex_regwrite_d = id_regwrite && (id_rd != '0);
                ex_memread_d  = id_memread;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rs1_q         <= '0;
            ex_rs2_q         <= '0;
            ex_rd_q          <= '0;
            ex_regwrite_q    <= 1'b0;
            ex_memread_q     <= 1'b0;
            exmem_rd_q       <= '0;
            exmem_regwrite_q <= 1'b0;
            memwb_rd_q       <= '0;
            memwb_regwrite_q <= 1'b0;
        end else begin
            ex_rs1_q         <= ex_rs1_d;
            ex_rs2_q         <= ex_rs2_d;
            ex_rd_q          <= ex_rd_d;
            ex_regwrite_q    <= ex_regwrite_d;
            ex_memread_q     <= ex_memread_d;
            exmem_rd_q       <= exmem_rd_d;
            exmem_regwrite_q <= exmem_regwrite_d;
            memwb_rd_q       <= memwb_rd_d;
            memwb_regwrite_q <= memwb_regwrite_d;
        end
    end

    assign ex_rs1         = ex_rs1_q;
    assign ex_rs2         = ex_rs2_q;
    assign exmem_rd       = exmem_rd_q;
    assign exmem_regwrite = exmem_regwrite_q;
    assign memwb_rd       = memwb_rd_q;
    assign memwb_regwrite = memwb_regwrite_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// tb/tb_hazard_pipe_ctrl.sv - directed scoreboard bench for hazard_pipe_ctrl (MULDIV_STALL_EN optional)
module tb_hazard_pipe_ctrl;

    localparam int RB = 5;
    localparam int EX1 = 0, EX2 = 1, EMRD = 2, EMWE = 3, MWRD = 4, MWWE = 5, STL = 6, BSY = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [RB-1:0] id_rs1, id_rs2, id_rd;
    logic          id_regwrite, id_memread, id_div, flush;
    logic [RB-1:0] ex_rs1, ex_rs2, exmem_rd, memwb_rd;
    logic          exmem_regwrite, memwb_regwrite, stall, div_busy;

    always #5 clk = ~clk;

    hazard_pipe_ctrl #(.REG_BITS(RB), .DIV_LAT(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_div(id_div),
        .flush(flush),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
        .stall(stall), .div_busy(div_busy)
    );

    typedef struct {
        string         tag;
        int            sel;
        logic [RB-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [RB-1:0] observe(int sel);
        logic [RB-1:0] r;
        r = '0;
        case (sel)
            EX1:     r = ex_rs1;
            EX2:     r = ex_rs2;
            EMRD:    r = exmem_rd;
            EMWE:    r[0] = exmem_regwrite;
            MWRD:    r = memwb_rd;
            MWWE:    r[0] = memwb_regwrite;
            STL:     r[0] = stall;
            default: r[0] = div_busy;
        endcase
        return r;
    endfunction

    task automatic expect_val(string tag, int sel, int v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = RB'(v);
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t          e;
        logic [RB-1:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_cmp++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic expect_all_zero(string tag);
        for (int s = 0; s < 8; s++) expect_val(tag, s, 0);
    endtask

    task automatic dec(input logic v, input int rs1, input int rs2, input int rd,
                       input logic we, input logic mr, input logic dv);
        id_valid    = v;
        id_rs1      = RB'(rs1);
        id_rs2      = RB'(rs2);
        id_rd       = RB'(rd);
        id_regwrite = we;
        id_memread  = mr;
        id_div      = dv;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        dec(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        expect_all_zero("reset_state");
        check_sb();
        rst = 1'b0;

        // Basic capture and stage progression
        dec(1, 1, 2, 5, 1, 0, 0);
        tick();
        expect_val("cap_ex_rs1", EX1, 1);
        expect_val("cap_ex_rs2", EX2, 2);
        check_sb();
        dec(0, 9, 9, 9, 1, 0, 0);
        tick();
        expect_val("cap_exmem_rd", EMRD, 5);
        expect_val("cap_exmem_we", EMWE, 1);
        expect_val("invalid_bubble_rs1", EX1, 0);
        check_sb();
        tick();
        expect_val("cap_memwb_rd", MWRD, 5);
        expect_val("cap_memwb_we", MWWE, 1);
        expect_val("bubble_exmem_we", EMWE, 0);
        check_sb();

        // Load-use: one stall, one bubble, then dependent add advances
        dec(1, 1, 0, 7, 1, 1, 0);
        tick();
        dec(1, 7, 3, 9, 1, 0, 0);
        #1;
        expect_val("lu_stall", STL, 1);
        check_sb();
        tick();
        expect_val("lu_bubble_rs1", EX1, 0);
        expect_val("lu_bubble_rs2", EX2, 0);
        expect_val("lu_exmem_rd", EMRD, 7);
        expect_val("lu_exmem_we", EMWE, 1);
        expect_val("lu_stall_released", STL, 0);
        check_sb();
        tick();
        expect_val("lu_add_rs1", EX1, 7);
        expect_val("lu_add_rs2", EX2, 3);
        expect_val("lu_memwb_rd", MWRD, 7);
        expect_val("lu_memwb_we", MWWE, 1);
        expect_val("lu_exmem_bubble_we", EMWE, 0);
        check_sb();

        // Load to x0 never advertises a write nor stalls
        dec(1, 1, 0, 0, 1, 1, 0);
        tick();
        dec(1, 4, 0, 6, 1, 0, 0);
        #1;
        expect_val("x0_no_stall", STL, 0);
        check_sb();
        tick();
        expect_val("x0_exmem_rd", EMRD, 0);
        expect_val("x0_exmem_we", EMWE, 0);
        expect_val("x0_add_rs1", EX1, 4);
        check_sb();

        // Flush together with load-use: bubble, no stall
        dec(1, 1, 0, 3, 1, 1, 0);
        tick();
        dec(1, 3, 0, 10, 1, 0, 0);
        flush = 1'b1;
        #1;
        expect_val("fl_lu_no_stall", STL, 0);
        check_sb();
        tick();
        flush = 1'b0;
        dec(0, 0, 0, 0, 0, 0, 0);
        expect_val("fl_bubble_rs1", EX1, 0);
        expect_val("fl_exmem_rd", EMRD, 3);
        expect_val("fl_exmem_we", EMWE, 1);
        check_sb();
        tick();
        expect_val("fl_bubble_rd", EMRD, 0);
        expect_val("fl_bubble_we", EMWE, 0);
        check_sb();

        // Asynchronous reset while a load-use stall is active
        dec(1, 1, 0, 7, 1, 1, 0);
        tick();
        dec(1, 7, 0, 8, 1, 0, 0);
        #1;
        expect_val("rst_pre_stall", STL, 1);
        check_sb();
        rst = 1'b1;
        #1;
        expect_all_zero("rst_async");
        check_sb();
        @(negedge clk);
        rst = 1'b0;
        dec(1, 1, 2, 5, 1, 0, 0);
        tick();
        dec(0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_val("rst_after_exmem_rd", EMRD, 5);
        expect_val("rst_after_exmem_we", EMWE, 1);
        check_sb();

`ifdef MULDIV_STALL_EN
        dec(1, 0, 0, 11, 1, 0, 0);
        tick();
        dec(1, 0, 0, 12, 1, 0, 0);
        tick();
        dec(1, 1, 2, 13, 1, 0, 1);
        tick();
        dec(1, 13, 0, 14, 1, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            expect_val("div_busy", BSY, 1);
            expect_val("div_stall", STL, 1);
            expect_val("div_ex_rs1", EX1, 1);
            expect_val("div_exmem_rd", EMRD, 12);
            expect_val("div_memwb_rd", MWRD, 11);
            check_sb();
            flush = (c == 1);
            tick();
            flush = 1'b0;
        end
        expect_val("div_done_busy", BSY, 0);
        expect_val("div_done_stall", STL, 0);
        expect_val("div_done_ex_rs1", EX1, 1);
        expect_val("div_done_exmem_rd", EMRD, 12);
        check_sb();
        tick();
        expect_val("div_add_rs1", EX1, 13);
        expect_val("div_add_exmem_rd", EMRD, 13);
        expect_val("div_add_memwb_rd", MWRD, 12);
        check_sb();
`else
        dec(1, 1, 2, 13, 1, 0, 1);
        #1;
        expect_val("nodiv_stall", STL, 0);
        check_sb();
        tick();
        expect_val("nodiv_busy", BSY, 0);
        expect_val("nodiv_ex_rs1", EX1, 1);
        check_sb();
        tick();
        expect_val("nodiv_exmem_rd", EMRD, 13);
        check_sb();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
